// File: rtl/priv_access_initiator.sv
// Privileged access initiator: level-checks each command against a 4-region table, then issues it to a responder.
// Optional audit outputs (deny_count, last_deny_addr, last_deny_level) are enabled by defining PRIV_AUDIT_LOG_EN.
module priv_access_initiator #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [7:0]  cmd_level,
   output logic        cmd_ready,
   output logic        priv_read_req,
   output logic        priv_write_req,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_grant,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_region,
   input  logic [7:0]  cfg_level
`ifdef PRIV_AUDIT_LOG_EN
   ,
   output logic [15:0] deny_count,
   output logic [7:0]  last_deny_addr,
   output logic [7:0]  last_deny_level
`endif
);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_DENIED  = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CHECK, ISSUE, RESP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  lvl_tbl [4];
   logic [7:0]  addr_q;
   logic [31:0] wdata_q;
   logic        write_q;
   logic [7:0]  level_q;
   logic [7:0]  req_lvl_q;
   logic [7:0]  to_cnt;
   logic [31:0] rsp_rdata_q;
   logic [1:0]  rsp_status_q;
   logic        accept;
   logic        allowed;
   logic        to_hit;

   assign accept  = cmd_valid && (state == IDLE);
   assign allowed = (level_q >= req_lvl_q);
   assign to_hit  = (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = CHECK;
         CHECK:   state_nxt = allowed ? ISSUE : RESP;
         ISSUE:   if (mem_grant || to_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and bus are decoded from the state so an async reset removes them at once.
   always_comb begin
      cmd_ready      = (state == IDLE);
      rsp_valid      = (state == RESP);
      priv_read_req  = 1'b0;
      priv_write_req = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      if (state == ISSUE) begin
         priv_read_req  = !write_q;
         priv_write_req = write_q;
         mem_addr       = addr_q;
         mem_wdata      = wdata_q;
      end
   end

   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_status = rsp_status_q;

   // Required level is sampled before any same-edge table write lands.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q    <= cmd_addr;
         wdata_q   <= cmd_wdata;
         write_q   <= cmd_write;
         level_q   <= cmd_level;
         req_lvl_q <= lvl_tbl[cmd_addr[7:6]];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) lvl_tbl[i] <= 8'hFF;
      end else if (cfg_we) begin
         lvl_tbl[cfg_region] <= cfg_level;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
      end else if (state == CHECK) begin
         to_cnt <= '0;
      end else if ((state == ISSUE) && !mem_grant) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_rdata_q  <= '0;
         rsp_status_q <= ST_OK;
      end else if ((state == CHECK) && !allowed) begin
         rsp_rdata_q  <= '0;
         rsp_status_q <= ST_DENIED;
      end else if ((state == ISSUE) && mem_grant) begin
         rsp_rdata_q  <= write_q ? 32'd0 : mem_rdata;
         rsp_status_q <= ST_OK;
      end else if ((state == ISSUE) && to_hit) begin
         rsp_rdata_q  <= '0;
         rsp_status_q <= ST_TIMEOUT;
      end
   end

`ifdef PRIV_AUDIT_LOG_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deny_count      <= '0;
         last_deny_addr  <= '0;
         last_deny_level <= '0;
      end else if ((state == CHECK) && !allowed) begin
         deny_count      <= sat_inc16(deny_count);
         last_deny_addr  <= addr_q;
         last_deny_level <= level_q;
      end
   end
`endif

endmodule

// File: tb/tb_priv_access_initiator.sv
// Bench for priv_access_initiator: directed scenarios plus randomized transactions against a transaction-level model.
module tb_priv_access_initiator;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_write;
   logic [7:0]  cmd_addr, cmd_level;
   logic [31:0] cmd_wdata;
   logic        cmd_ready;
   logic        priv_read_req, priv_write_req;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_grant;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        cfg_we;
   logic [1:0]  cfg_region;
   logic [7:0]  cfg_level;
`ifdef PRIV_AUDIT_LOG_EN
   logic [15:0] deny_count;
   logic [7:0]  last_deny_addr, last_deny_level;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  tbl_m [4];
   int          deny_m;

   priv_access_initiator #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_level(cmd_level), .cmd_ready(cmd_ready),
      .priv_read_req(priv_read_req), .priv_write_req(priv_write_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_grant(mem_grant),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_level(cfg_level)
`ifdef PRIV_AUDIT_LOG_EN
      , .deny_count(deny_count), .last_deny_addr(last_deny_addr), .last_deny_level(last_deny_level)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] r, input logic [7:0] l);
      @(negedge clk);
      cfg_we = 1'b1; cfg_region = r; cfg_level = l;
      @(negedge clk);
      cfg_we = 1'b0;
      tbl_m[r] = l;
   endtask

   // gat: ISSUE cycle (1-based) on which the grant is given; outside 1..TO means never.
   // cfg_mode: 0 none, 1 table write in the acceptance cycle, 2 table write while waiting in RESP.
   task automatic run_txn(input logic [7:0] a, input logic w, input logic [31:0] wd, input logic [7:0] lv,
                          input int gat, input logic [31:0] rd, input int hold,
                          input int cfg_mode, input logic [1:0] cr, input logic [7:0] cl);
      logic [7:0]  req;
      logic [1:0]  exp_st, st0;
      logic [31:0] exp_rd, rd0;
      int          exp_lat, exp_stb, stb, lat;
      bit          bus_ok, busy_ok, stable_ok;
      @(negedge clk);
      chk("idle_ready", 64'(cmd_ready), 64'd1);
      req = tbl_m[a[7:6]];
      if (lv < req) begin
         exp_st = 2'b01; exp_rd = 0; exp_stb = 0; exp_lat = 2;
         if (deny_m < 65535) deny_m++;
      end else if (gat >= 1 && gat <= TO) begin
         exp_st = 2'b00; exp_rd = w ? 32'd0 : rd; exp_stb = gat; exp_lat = 2 + gat;
      end else begin
         exp_st = 2'b10; exp_rd = 0; exp_stb = TO; exp_lat = 2 + TO;
      end
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_level = lv;
      mem_rdata = rd; mem_grant = 1'b0;
      if (cfg_mode == 1) begin
         cfg_we = 1'b1; cfg_region = cr; cfg_level = cl; tbl_m[cr] = cl;
      end
      stb = 0; lat = 0; bus_ok = 1; busy_ok = 1;
      for (int n = 1; n <= TO + 8 && lat == 0; n++) begin
         @(negedge clk);
         cmd_valid = 1'b0; cfg_we = 1'b0;
         if (cmd_ready) busy_ok = 0;
         if (priv_read_req || priv_write_req) begin
            if (priv_read_req == priv_write_req || priv_write_req !== w ||
                mem_addr !== a || mem_wdata !== wd) bus_ok = 0;
            stb++;
         end else if (mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            bus_ok = 0;
         end
         mem_grant = (priv_read_req || priv_write_req) && (stb == gat);
         if (rsp_valid) lat = n;
      end
      mem_grant = 1'b0;
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("status", 64'(rsp_status), 64'(exp_st));
      chk("rdata", 64'(rsp_rdata), 64'(exp_rd));
      chk("strobe_cycles", 64'(stb), 64'(exp_stb));
      chk("bus_content", 64'(bus_ok), 64'd1);
      chk("busy_not_ready", 64'(busy_ok), 64'd1);
      rd0 = rsp_rdata; st0 = rsp_status; stable_ok = 1;
      for (int k = 0; k < hold; k++) begin
         if (cfg_mode == 2 && k == 0) begin
            cfg_we = 1'b1; cfg_region = cr; cfg_level = cl; tbl_m[cr] = cl;
         end
         @(negedge clk);
         cfg_we = 1'b0;
         if (!rsp_valid || rsp_rdata !== rd0 || rsp_status !== st0 || cmd_ready) stable_ok = 0;
      end
      if (hold > 0) chk("resp_stable", 64'(stable_ok), 64'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("resp_done", 64'({rsp_valid, cmd_ready}), 64'd1);
   endtask

   initial begin
      bit ok;
      reset_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_level = 0;
      mem_rdata = 0; mem_grant = 0; rsp_ready = 0; cfg_we = 0; cfg_region = 0; cfg_level = 0;
      for (int i = 0; i < 4; i++) tbl_m[i] = 8'hFF;
      deny_m = 0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", 64'({cmd_ready, priv_read_req, priv_write_req, rsp_valid, rsp_status}), 64'h20);
      chk("rst_data", 64'({mem_addr, mem_wdata} | 64'(rsp_rdata)), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);

      // Read granted on the second ISSUE cycle.
      run_txn(8'h10, 1'b0, 32'h0, 8'hFF, 2, 32'hDEADBEEF, 0, 0, 2'd0, 8'd0);
      // Denied write.
      cfg_write(2'd1, 8'h40);
      run_txn(8'h55, 1'b1, 32'hA5A5_1234, 8'h3F, 1, 32'h0, 0, 0, 2'd0, 8'd0);
`ifdef PRIV_AUDIT_LOG_EN
      chk("deny_count", 64'(deny_count), 64'(deny_m));
      chk("deny_addr_level", 64'({last_deny_addr, last_deny_level}), 64'h553F);
`endif
      // Timeout, then a grant on the final ISSUE cycle.
      cfg_write(2'd3, 8'h80);
      run_txn(8'hC0, 1'b1, 32'h1111_2222, 8'h80, 0, 32'h0, 0, 0, 2'd0, 8'd0);
      run_txn(8'hC0, 1'b0, 32'h0, 8'h80, TO, 32'h0BAD_F00D, 0, 0, 2'd0, 8'd0);
      // Long RESP wait with a table write to region 0, then confirm it applied.
      run_txn(8'h00, 1'b0, 32'h0, 8'hFF, 1, 32'h1234_5678, 5, 2, 2'd0, 8'h20);
      run_txn(8'h01, 1'b0, 32'h0, 8'h1F, 1, 32'h0, 0, 0, 2'd0, 8'd0);
      run_txn(8'h02, 1'b0, 32'h0, 8'h20, 1, 32'hCAFE_0001, 0, 0, 2'd0, 8'd0);
      // Same-cycle table write to the accepted region keeps the old level.
      cfg_write(2'd2, 8'h10);
      run_txn(8'h80, 1'b0, 32'h0, 8'h0F, 1, 32'h0, 0, 1, 2'd2, 8'h00);
      run_txn(8'h81, 1'b0, 32'h0, 8'h0F, 1, 32'h7777_0000, 0, 0, 2'd0, 8'd0);

      // Reset in the middle of ISSUE.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h5; cmd_level = 8'hFF;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("issue_before_rst", 64'(priv_write_req), 64'd1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk("async_strobe_drop", 64'({priv_read_req, priv_write_req}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) tbl_m[i] = 8'hFF;
      deny_m = 0;
      ok = 1;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid || !cmd_ready) ok = 0;
      end
      chk("no_rsp_after_rst", 64'(ok), 64'd1);
      for (int r = 0; r < 4; r++)
         run_txn({2'(r), 6'h05}, 1'b0, 32'h0, 8'hFE, 1, 32'h0, 0, 0, 2'd0, 8'd0);
`ifdef PRIV_AUDIT_LOG_EN
      chk("deny_count_rst", 64'(deny_count), 64'(deny_m));
`endif

      // Randomized transactions.
      for (int t = 0; t < 30; t++) begin
         logic [7:0] a, lv;
         int         d;
         if ($urandom_range(0, 2) == 0) cfg_write(2'($urandom), 8'($urandom));
         a  = 8'($urandom);
         d  = $urandom_range(0, 6);
         lv = 8'(int'(tbl_m[a[7:6]]) + d - 3);
         run_txn(a, 1'($urandom), $urandom, lv, $urandom_range(0, TO + 2), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom), 8'($urandom));
      end
`ifdef PRIV_AUDIT_LOG_EN
      chk("deny_count_rand", 64'(deny_count), 64'(deny_m));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
